// File: rtl/perf_pkg.sv
// Shared types and helpers for the pipeline performance counter block.
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE,
    PERF_RUN,
    PERF_DONE
  } perf_state_e;

  localparam int SEL_CYCLE = 0;

  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear; optional sticky overflow flag
// when PERF_OVF_FLAG_EN is defined.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
`ifdef PERF_OVF_FLAG_EN
  ,output logic            ovf
`endif
);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_max;

  assign at_max = (cnt_reg == {CNT_W{1'b1}});
  assign cnt    = cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (inc && !at_max) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

`ifdef PERF_OVF_FLAG_EN
  logic ovf_reg;

  // Sticky: an increment that the counter could not absorb.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      ovf_reg <= 1'b0;
    end else if (inc && at_max) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: rtl/pipe_perf_counter.sv
// Windowed cycle/event monitor for the pipelined CPU with a registered indexed
// readout. Define PERF_OVF_FLAG_EN to add the per-counter ovf_o flags.
module pipe_perf_counter
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = sel_width(NUM_EVT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic [CNT_W-1:0]   max_cycles_i,
  input  logic [NUM_EVT-1:0] evt_mask_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               busy_o,
  output logic               done_o
`ifdef PERF_OVF_FLAG_EN
  ,output logic [NUM_EVT:0]  ovf_o
`endif
);

  perf_state_e      state_reg, state_next;
  logic [CNT_W-1:0] lim_reg;
  logic [CNT_W-1:0] rd_data_reg, rd_mux;
  logic [CNT_W-1:0] cnt [NUM_EVT+1];
  logic [NUM_EVT:0] inc;
  logic             run, clr, limit_hit;
  logic [CNT_W:0]   cyc_next_ext;

  assign run = (state_reg == PERF_RUN);
  assign clr = ((state_reg == PERF_IDLE) && start_i) ||
               ((state_reg == PERF_DONE) && clear_i);
  assign inc = {evt_i & evt_mask_i & {NUM_EVT{run}}, run};

  // Compare one bit wider so a saturated cycle counter can never alias the limit.
  assign cyc_next_ext = {1'b0, cnt[SEL_CYCLE]} + {{CNT_W{1'b0}}, 1'b1};
  assign limit_hit    = (lim_reg != '0) && (cyc_next_ext == {1'b0, lim_reg});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= PERF_IDLE;
      lim_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == PERF_IDLE) && start_i) begin
        lim_reg <= max_cycles_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      PERF_IDLE: if (start_i) state_next = PERF_RUN;
      PERF_RUN:  if (stop_i || limit_hit) state_next = PERF_DONE;
      PERF_DONE: if (clear_i) state_next = PERF_IDLE;
      default:   state_next = PERF_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
      perf_sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk_i),
        .srst (rst_i),
        .clr  (clr),
        .inc  (inc[gi]),
        .cnt  (cnt[gi])
`ifdef PERF_OVF_FLAG_EN
        ,.ovf (ovf_o[gi])
`endif
      );
    end
  endgenerate

  // Unmatched selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux;
    end
  end

  assign rd_data_o = rd_data_reg;
  assign busy_o    = (state_reg == PERF_RUN);
  assign done_o    = (state_reg == PERF_DONE);

endmodule
